// File: rtl/pipe_prbs_checker.sv
// PRBS-8 (x^8+x^6+x^5+x^4+1) stream checker.
// Hunts for a run of predicted words, then free-runs its own sequence.
module pipe_prbs_checker #(
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned LOSS_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  data_in,
  output logic        locked,
  output logic        err_flag,
  output logic [15:0] err_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  function automatic logic [7:0] prbs_nxt(
    input logic [7:0] x
  );
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  prev_q;
  logic [7:0]  prev_d;
  logic [7:0]  exp_q;
  logic [7:0]  exp_d;
  logic [3:0]  mc_q;
  logic [3:0]  mc_d;
  logic [3:0]  mm_q;
  logic [3:0]  mm_d;
  logic [15:0] cnt_d;
  logic        flag_d;
  logic        hunt_hit;
  logic        lock_hit;

  // The all-zero word is the LFSR lock-up state and never counts.
  assign hunt_hit = (data_in == prbs_nxt(prev_q)) &&
                    (data_in != 8'h00);
  assign lock_hit = (data_in == exp_q);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    exp_d   = exp_q;
    mc_d    = mc_q;
    mm_d    = mm_q;
    cnt_d   = err_cnt;
    flag_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          prev_d = data_in;
          if (!hunt_hit) begin
            mc_d = 4'd0;
          end else if (mc_q == LOCK_T - 4'd1) begin
            state_d = LOCKED;
            exp_d   = prbs_nxt(data_in);
            mc_d    = 4'd0;
            mm_d    = 4'd0;
          end else begin
            mc_d = mc_q + 4'd1;
          end
        end
        LOCKED: begin
          // Free-running prediction: never reseeded from data.
          exp_d = prbs_nxt(exp_q);
          if (lock_hit) begin
            mm_d = 4'd0;
          end else begin
            flag_d = 1'b1;
            if (err_cnt != 16'hFFFF) begin
              cnt_d = err_cnt + 16'd1;
            end
            if (mm_q == LOSS_T - 4'd1) begin
              state_d = HUNT;
              mc_d    = 4'd0;
              mm_d    = 4'd0;
              prev_d  = data_in;
            end else begin
              mm_d = mm_q + 4'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clr) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      prev_q   <= 8'h00;
      exp_q    <= 8'h00;
      mc_q     <= 4'd0;
      mm_q     <= 4'd0;
      err_cnt  <= 16'd0;
      err_flag <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      exp_q    <= exp_d;
      mc_q     <= mc_d;
      mm_q     <= mm_d;
      err_cnt  <= cnt_d;
      err_flag <= flag_d;
      locked   <= (state_d == LOCKED);
    end
  end

endmodule

// File: tb/tb_pipe_prbs_checker.sv
// Scoreboard bench for pipe_prbs_checker.
// Second instance uses LOSS_THRESH=15 for the saturation run.
module tb_pipe_prbs_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_cnt;

  logic        en2 = 1'b0;
  logic        clr2 = 1'b0;
  logic [7:0]  data2 = 8'h00;
  logic        locked2;
  logic        err_flag2;
  logic [15:0] err_cnt2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_prbs_checker #(.LOCK_THRESH(LOCK), .LOSS_THRESH(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .data_in(data), .locked(locked),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );

  pipe_prbs_checker #(.LOCK_THRESH(4), .LOSS_THRESH(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2),
    .data_in(data2), .locked(locked2),
    .err_flag(err_flag2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nx(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  // reference model
  logic        m_lk;
  logic        m_flag;
  int          m_mc;
  int          m_mm;
  logic [7:0]  m_prev;
  logic [7:0]  m_exp;
  logic [15:0] m_cnt;
  logic [17:0] sb[$];

  task automatic mdl_rst();
    m_lk = 0; m_flag = 0; m_mc = 0; m_mm = 0;
    m_prev = 0; m_exp = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic mdl(input logic e, input logic c,
                     input logic [7:0] d);
    logic f;
    f = 1'b0;
    if (e && !m_lk) begin
      if (d != 8'h00 && d == nx(m_prev)) begin
        m_mc++;
        if (m_mc >= LOCK) begin
          m_lk = 1; m_exp = nx(d); m_mc = 0; m_mm = 0;
        end
      end else begin
        m_mc = 0;
      end
      m_prev = d;
    end else if (e) begin
      if (d == m_exp) begin
        m_mm = 0;
      end else begin
        f = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
        m_mm++;
        if (m_mm >= LOSS) begin
          m_lk = 0; m_mc = 0; m_mm = 0; m_prev = d;
        end
      end
      m_exp = nx(m_exp);
    end
    if (c) m_cnt = 16'd0;
    m_flag = f;
  endtask

  task automatic step(input logic e, input logic c,
                      input logic [7:0] d);
    en = e; clr = c; data = d;
    mdl(e, c, d);
    sb.push_back({m_lk, m_flag, m_cnt});
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else chk("seq", {14'd0, locked, err_flag, err_cnt},
             {14'd0, sb.pop_front()});
  endtask

  task automatic step2(input logic c, input logic [7:0] d);
    en2 = 1'b1; clr2 = c; data2 = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] s;
  logic [7:0] e2;
  logic [7:0] lst [5];
  logic [15:0] keep;

  initial begin
    lst[0] = 8'h01; lst[1] = 8'h02; lst[2] = 8'h04;
    lst[3] = 8'h08; lst[4] = 8'h11;
    mdl_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_cnt", err_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1, 0, lst[i]);
      if (i == 3) chk("prelock", locked, 0);
    end
    chk("lock_11", locked, 1);
    chk("lock_cnt", err_cnt, 0);

    step(1, 0, 8'h23);
    step(1, 0, 8'h00);
    chk("inj_flag", err_flag, 1);
    chk("inj_cnt", err_cnt, 1);
    step(1, 0, 8'h8E);
    chk("inj_flag_end", err_flag, 0);
    chk("inj_locked", locked, 1);

    s = nx(8'h8E);
    step(1, 1, s);
    chk("clr_cnt", err_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      s = nx(s);
      step(1, 0, ~s);
      if (i < 2) chk("loss_hold", locked, 1);
    end
    chk("loss_cnt", err_cnt, 3);
    chk("loss_locked", locked, 0);
    for (int i = 0; i < 5; i++) begin
      s = nx(s);
      step(1, 0, s);
      if (i == 3) chk("relock_early", locked, 0);
    end
    chk("relock", locked, 1);

    keep = err_cnt;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'($urandom));
      chk("en_lo_flag", err_flag, 0);
    end
    for (int i = 0; i < 6; i++) begin
      s = nx(s);
      step(1, 0, s);
    end
    chk("en_resume_cnt", err_cnt, keep);
    chk("en_resume_lock", locked, 1);

    for (int i = 0; i < 300; i++) begin
      logic ev;
      logic cv;
      logic [7:0] dv;
      ev = ($urandom_range(9) != 0);
      cv = ($urandom_range(19) == 0);
      if (ev) s = nx(s);
      dv = ($urandom_range(7) == 0) ? 8'($urandom) : s;
      step(ev, cv, dv);
    end

    for (int i = 0; i < 6; i++) begin
      s = nx(s);
      step(1, 0, s);
    end
    s = nx(s);
    step(1, 0, ~s);
    chk("pre_rst_lock", locked, 1);
    chk("pre_rst_cnt", err_cnt != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_flag", err_flag, 0);
    chk("async_cnt", err_cnt, 0);
    mdl_rst();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s = nx(s);
      step(1, 0, s);
      if (i == 3) chk("rst_relock_early", locked, 0);
    end
    chk("rst_relock", locked, 1);

    rst_n = 1'b0;
    mdl_rst();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 0, 8'h00);
    chk("zero_locked", locked, 0);
    chk("zero_cnt", err_cnt, 0);
    en = 1'b0;

    for (int i = 0; i < 5; i++) step2(0, lst[i]);
    chk("sat_lock", locked2, 1);
    e2 = 8'h23;
    for (int g = 0; g < 4682; g++) begin
      for (int k = 0; k < 14; k++) begin
        step2(0, ~e2);
        e2 = nx(e2);
      end
      step2(0, e2);
      e2 = nx(e2);
    end
    chk("sat_cnt", err_cnt2, 16'hFFFF);
    chk("sat_locked", locked2, 1);
    step2(0, ~e2);
    e2 = nx(e2);
    chk("sat_hold", err_cnt2, 16'hFFFF);
    chk("sat_flag", err_flag2, 1);
    step2(1, ~e2);
    e2 = nx(e2);
    chk("sat_clr_cnt", err_cnt2, 0);
    chk("sat_clr_flag", err_flag2, 1);
    chk("sat_clr_lock", locked2, 1);
    en2 = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_prbs_checker.md
PIPE_PRBS_CHECKER -- requirements
Module: pipe_prbs_checker

Interface
REQ-001 Parameters SHALL be: LOCK_THRESH, 4, consecutive predicted-word matches needed to lock (1..15).
REQ-002 Parameters SHALL be: LOSS_THRESH, 3, consecutive mismatches while locked needed to drop lock (1..15).
REQ-003 Ports SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-004 Ports SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports SHALL be: en  input  1  sample-valid; when low all state holds.
REQ-006 Ports SHALL be: clr  input  1  synchronous clear of err_cnt.
REQ-007 Ports SHALL be: data_in  input  8  received word from the 8-stage pipeline output.
REQ-008 Ports SHALL be: locked  output  1  checker is synchronised to the PRBS stream.
REQ-009 Ports SHALL be: err_flag  output  1  one-cycle pulse per mismatched word while locked.
REQ-010 Ports SHALL be: err_cnt  output  16  saturating count of mismatched words.

Function
REQ-011 The PRBS SHALL be the 8-bit polynomial x^8+x^6+x^5+x^4+1; nxt(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}.
REQ-012 The FSM SHALL have two states, HUNT and LOCKED; all outputs SHALL be registered.
REQ-013 HUNT, en=1: if data_in == nxt(prev) and data_in != 0x00, match_cnt increments, else match_cnt clears; prev <= data_in every enabled cycle.
REQ-014 HUNT: on the enabled edge where match_cnt reaches LOCK_THRESH, state <= LOCKED, expected <= nxt(data_in), locked rises on that same edge.
REQ-015 A 0x00 word SHALL never count as a match (the lock-up state is rejected).
REQ-016 LOCKED, en=1: compare data_in against expected; expected <= nxt(expected) regardless of result (no reseed from data).
REQ-017 LOCKED mismatch: err_flag = 1 for the following cycle, err_cnt += 1 saturating at 0xFFFF, miss_cnt increments; match clears miss_cnt.
REQ-018 LOCKED: when miss_cnt reaches LOSS_THRESH, state <= HUNT, locked falls on that edge, match_cnt <= 0, prev <= data_in.
REQ-019 Mismatches in HUNT SHALL NOT assert err_flag or change err_cnt.
REQ-020 en=0: state, prev, expected, counters hold; err_flag = 0; clr still acts.
REQ-021 clr=1 coincident with a mismatch: err_cnt <= 0 (clr wins), err_flag still pulses; clr never affects lock state.
REQ-022 err_cnt at 0xFFFF plus a mismatch SHALL stay 0xFFFF; err_flag still pulses.

Reset
REQ-023 rst_n low SHALL immediately force state=HUNT, locked=0, err_flag=0, err_cnt=0, match_cnt=0, miss_cnt=0, prev=0x00, expected=0x00.
REQ-024 Reset asserted mid-lock or mid-hunt SHALL discard all progress; after release a full LOCK_THRESH match run is required again.
REQ-025 Reset deassertion SHALL be treated as synchronous to clk by the integrator; the block adds no synchroniser.

Verification
REQ-026 Feed 0x01,0x02,0x04,0x08,0x11 with en=1 -> locked=1 at the edge sampling 0x11; err_cnt=0.
REQ-027 Locked, continue 0x23 then inject 0x00 in place of 0x47, resume 0x8E -> single err_flag pulse, err_cnt=1, locked stays 1.
REQ-028 Locked, apply 3 consecutive wrong words -> err_cnt=3, locked falls on 3rd; next 5 correct consecutive PRBS words relock.
REQ-029 Hold data_in=0x00 for 20 cycles from reset -> locked stays 0, err_cnt=0.
REQ-030 Preload err_cnt to 0xFFFF via long error run with LOSS_THRESH=15 and periodic correct words, then mismatch + clr same cycle -> err_cnt=0, err_flag=1.
REQ-031 Toggle en low for 4 cycles mid-stream while locked, resume correct sequence -> no errors; pulse rst_n mid-lock -> all outputs 0 asynchronously.
